// File: rtl/mavg_pkg.sv
// Shared width helpers for the multi-channel moving-average filter.
// Widths depend on the module parameters, so they are provided as functions.
package mavg_pkg;

    function automatic int ch_w(input int c);
        return (c > 1) ? $clog2(c) : 1;
    endfunction

    function automatic int ptr_w(input int mmax);
        return mmax;
    endfunction

    function automatic int sum_w(input int n, input int mmax);
        return n + mmax;
    endfunction

    function automatic int win_w(input int mmax);
        return (mmax > 0) ? $clog2(mmax + 1) : 1;
    endfunction

endpackage

// File: rtl/mavg_chan.sv
// One channel of the moving-average filter.
// Holds the history buffer, write pointer, fill count and running sum.
module mavg_chan
    import mavg_pkg::*;
#(
    parameter int MMAX = 4,
    parameter int N    = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush,
    input  logic                      accept,
    input  logic [N-1:0]              s,
    input  logic [win_w(MMAX)-1:0]    m,
    output logic [sum_w(N, MMAX)-1:0] sum_new,
    output logic                      full_new
);
    localparam int PTR_W = ptr_w(MMAX);
    localparam int SUM_W = sum_w(N, MMAX);
    localparam int DEPTH = 1 << MMAX;

    logic [N-1:0]     buf_mem [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W:0]   fill;
    logic [PTR_W:0]   fill_new;
    logic [PTR_W:0]   win;
    logic [SUM_W-1:0] sum;
    logic [N-1:0]     old;
    logic             full;

    // For m == MMAX the low bits of win are zero, so the oldest sample sits at wp itself.
    always_comb begin
        win      = (PTR_W + 1)'(1) << m;
        full     = (fill == win);
        old      = full ? buf_mem[wp - win[PTR_W-1:0]] : '0;
        sum_new  = sum + {{MMAX{1'b0}}, s} - {{MMAX{1'b0}}, old};
        fill_new = full ? fill : fill + (PTR_W + 1)'(1);
        full_new = (fill_new == win);
    end

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wp   <= '0;
            fill <= '0;
            sum  <= '0;
        end else if (accept) begin
            wp   <= wp + PTR_W'(1);
            fill <= fill_new;
            sum  <= sum_new;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_mem[wp] <= s;
        end
    end

endmodule

// File: rtl/mavg_filter_mc.sv
// Multi-channel moving-average filter: channel decode, window exponent latch,
// rounding/shift and the registered output beat.
module mavg_filter_mc
    import mavg_pkg::*;
#(
    parameter int C     = 4,
    parameter int MMAX  = 4,
    parameter int N     = 16,
    parameter int ROUND = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N-1:0]           sample,
    input  logic [ch_w(C)-1:0]     sample_ch,
    input  logic                   sample_valid,
    input  logic                   flush,
    input  logic [win_w(MMAX)-1:0] win_log2,
    output logic [N-1:0]           average,
    output logic [ch_w(C)-1:0]     average_ch,
    output logic                   average_valid,
    output logic                   ch_err
);
    localparam int CH_W  = ch_w(C);
    localparam int WIN_W = win_w(MMAX);
    localparam int SUM_W = sum_w(N, MMAX);
    localparam logic [CH_W:0]  C_L    = (CH_W + 1)'(C);
    localparam logic [WIN_W-1:0] MMAX_L = WIN_W'(MMAX);

    typedef struct packed {
        logic [N-1:0]    average;
        logic [CH_W-1:0] ch;
        logic            valid;
    } beat_t;

    beat_t            beat_q;
    logic [WIN_W-1:0] m;
    logic             ch_ok;
    logic             accept_any;
    logic [C-1:0]     acc;
    logic [SUM_W-1:0] sum_arr  [C];
    logic [C-1:0]     full_arr;
    logic [SUM_W-1:0] sel_sum;
    logic             sel_full;
    logic [SUM_W:0]   rnd;
    logic [SUM_W:0]   shifted;

    assign ch_ok      = ({1'b0, sample_ch} < C_L);
    assign accept_any = sample_valid && !flush && ch_ok;

    for (genvar c = 0; c < C; c++) begin : g_chan
        assign acc[c] = accept_any && (sample_ch == CH_W'(c));

        mavg_chan #(
            .MMAX (MMAX),
            .N    (N)
        ) u_chan (
            .clk      (clk),
            .rstn     (rstn),
            .flush    (flush),
            .accept   (acc[c]),
            .s        (sample),
            .m        (m),
            .sum_new  (sum_arr[c]),
            .full_new (full_arr[c])
        );
    end

    always_comb begin
        sel_sum  = '0;
        sel_full = 1'b0;
        for (int unsigned i = 0; i < C; i++) begin
            if (acc[i]) begin
                sel_sum  = sum_arr[i];
                sel_full = full_arr[i];
            end
        end
        rnd     = (ROUND != 0 && m != '0) ? ((SUM_W + 1)'(1) << (m - WIN_W'(1))) : '0;
        shifted = ({1'b0, sel_sum} + rnd) >> m;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            m <= MMAX_L;
        end else if (flush) begin
            m <= (win_log2 > MMAX_L) ? MMAX_L : win_log2;
        end
    end

    // Flush has priority over an invalid-channel sample in the same cycle.
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            ch_err <= 1'b0;
        end else if (sample_valid && !ch_ok) begin
            ch_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            beat_q <= '0;
        end else begin
            beat_q.valid <= accept_any && sel_full;
            if (accept_any && sel_full) begin
                beat_q.average <= shifted[N-1:0];
                beat_q.ch      <= sample_ch;
            end
        end
    end

    assign average       = beat_q.average;
    assign average_ch    = beat_q.ch;
    assign average_valid = beat_q.valid;

endmodule

// File: tb/tb_mavg_filter_mc.sv
// Randomised and directed checks of mavg_filter_mc against a queue-based
// window model; two builds (C=4 truncating, C=3 rounding) share the stimulus.
module tb_mavg_filter_mc;
    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] sample;
    logic [1:0]  sample_ch;
    logic        sample_valid;
    logic        flush;
    logic [2:0]  win_log2;

    logic [15:0] avg0, avg1;
    logic [1:0]  ach0, ach1;
    logic        vld0, vld1, err0, err1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mavg_filter_mc #(.C(4), .MMAX(4), .N(16), .ROUND(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .sample(sample), .sample_ch(sample_ch),
        .sample_valid(sample_valid), .flush(flush), .win_log2(win_log2),
        .average(avg0), .average_ch(ach0), .average_valid(vld0), .ch_err(err0)
    );

    mavg_filter_mc #(.C(3), .MMAX(4), .N(16), .ROUND(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .sample(sample), .sample_ch(sample_ch),
        .sample_valid(sample_valid), .flush(flush), .win_log2(win_log2),
        .average(avg1), .average_ch(ach1), .average_valid(vld1), .ch_err(err1)
    );

    // Reference model: the window is simply the last 2^m accepted samples per channel.
    int          nch  [2] = '{4, 3};
    int          rmode[2] = '{0, 1};
    int unsigned hist [2][4][$];
    int          mexp [2];
    int unsigned e_avg[2];
    int unsigned e_ch [2];
    int unsigned e_vld[2];
    int unsigned e_err[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (!rstn) begin
                for (int c = 0; c < 4; c++) hist[d][c].delete();
                mexp[d]  = 4;
                e_avg[d] = 0; e_ch[d] = 0; e_vld[d] = 0; e_err[d] = 0;
            end else if (flush) begin
                for (int c = 0; c < 4; c++) hist[d][c].delete();
                mexp[d]  = (int'(win_log2) > 4) ? 4 : int'(win_log2);
                e_vld[d] = 0; e_err[d] = 0;
            end else begin
                e_vld[d] = 0;
                if (sample_valid) begin
                    if (int'(sample_ch) >= nch[d]) begin
                        e_err[d] = 1;
                    end else begin
                        int c;
                        c = int'(sample_ch);
                        hist[d][c].push_back(int'(sample));
                        if (hist[d][c].size() > (1 << mexp[d])) void'(hist[d][c].pop_front());
                        if (hist[d][c].size() == (1 << mexp[d])) begin
                            longint unsigned tot;
                            tot = 0;
                            foreach (hist[d][c][k]) tot += hist[d][c][k];
                            if (rmode[d] != 0 && mexp[d] > 0) tot += (64'd1 << (mexp[d] - 1));
                            e_avg[d] = int'((tot >> mexp[d]) & 64'hFFFF);
                            e_ch[d]  = c;
                            e_vld[d] = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check("vld0", 32'(vld0), e_vld[0]);
        check("avg0", 32'(avg0), e_avg[0]);
        check("ach0", 32'(ach0), e_ch[0]);
        check("err0", 32'(err0), e_err[0]);
        check("vld1", 32'(vld1), e_vld[1]);
        check("avg1", 32'(avg1), e_avg[1]);
        check("ach1", 32'(ach1), e_ch[1]);
        check("err1", 32'(err1), e_err[1]);
    endtask

    task automatic cyc(input bit r, input bit v, input int ch, input int s,
                       input bit fl, input int w);
        rstn         = r;
        sample_valid = v;
        sample_ch    = 2'(ch);
        sample       = 16'(s);
        flush        = fl;
        win_log2     = 3'(w);
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        rstn = 1'b0; sample = '0; sample_ch = '0; sample_valid = 1'b0;
        flush = 1'b0; win_log2 = '0;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 77, 0, 0);

        // Window of 4 on ch0
        cyc(1, 0, 0, 0, 1, 2);
        cyc(1, 1, 0, 4, 0, 0);
        cyc(1, 1, 0, 8, 0, 0);
        cyc(1, 1, 0, 12, 0, 0);
        check("tp_pre_full", 32'(vld0), 0);
        cyc(1, 1, 0, 16, 0, 0);
        check("tp_avg10", 32'(avg0), 10);
        cyc(1, 1, 0, 20, 0, 0);
        check("tp_avg14", 32'(avg0), 14);

        // Interleaved channels, window of 2
        cyc(1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 8; i++) cyc(1, 1, i % 2, (i % 2) ? 200 : 100, 0, 0);
        check("tp_alt_ch", 32'(ach0), 1);
        check("tp_alt_avg", 32'(avg0), 200);

        // Full-scale window of 16, ch3 on C=4 and ch2 on the rounding build
        cyc(1, 0, 0, 0, 1, 4);
        for (int i = 0; i < 16; i++) cyc(1, 1, 3, 16'hFFFF, 0, 0);
        check("tp_ffff", 32'(avg0), 32'hFFFF);
        cyc(1, 1, 3, 0, 0, 0);
        check("tp_61439", 32'(avg0), 61439);
        for (int i = 0; i < 16; i++) cyc(1, 1, 2, 16'hFFFF, 0, 0);
        check("tp_ffff_r", 32'(avg1), 32'hFFFF);
        cyc(1, 1, 2, 0, 0, 0);
        check("tp_61439_r", 32'(avg1), 61439);

        // Flush together with a sample and an oversized exponent
        cyc(1, 1, 0, 123, 1, 7);
        check("tp_flush_vld", 32'(vld0), 0);
        for (int i = 0; i < 15; i++) cyc(1, 1, 0, i, 0, 0);
        check("tp_clamp_wait", 32'(vld0), 0);
        cyc(1, 1, 0, 15, 0, 0);
        check("tp_clamp_out", 32'(vld0), 1);

        // m = 0
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 1, 2, 5, 0, 0);
        check("tp_m0_5", 32'(avg0), 5);
        cyc(1, 1, 2, 9, 0, 0);
        cyc(1, 1, 2, 0, 0, 0);
        check("tp_m0_0", 32'(avg0), 0);

        // Invalid channel on the C=3 build, then mid-stream reset
        cyc(1, 1, 3, 42, 0, 0);
        check("tp_err1", 32'(err1), 1);
        check("tp_noerr0", 32'(err0), 0);
        cyc(0, 1, 2, 42, 0, 0);
        check("tp_rst_err", 32'(err1), 0);
        check("tp_rst_avg", 32'(avg0), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, fl, v;
            int s;
            r  = ($urandom_range(0, 299) != 0);
            fl = ($urandom_range(0, 79) == 0);
            v  = ($urandom_range(0, 3) != 0);
            s  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : int'($urandom_range(0, 16'hFFFF));
            cyc(r, v, int'($urandom_range(0, 3)), s, fl, int'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
